decode_stage: RTL and testbench

//  Registered RV32I(+M subset) decode stage between fetch and execute. Accepts a

---
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+mul/mulh) decode with a 2-entry skid buffer between fetch and execute
module decode_stage #(
  parameter int PC_W     = 32,
  parameter int ENABLE_M = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       op_type,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      offset,
  output logic [31:0]      immediate,
  output logic             illegal,
  output logic [PC_W-1:0]  pc_out,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [4:0] I_NULL = 5'd0, I_ADD = 5'd1, I_SUB = 5'd2, I_MUL = 5'd3, I_MULH = 5'd4,
                         I_XOR = 5'd5, I_OR = 5'd6, I_AND = 5'd7, I_ADDI = 5'd8, I_BEQ = 5'd9,
                         I_BNE = 5'd10, I_BLT = 5'd11, I_BGE = 5'd12, I_LW = 5'd13, I_SW = 5'd14,
                         I_JAL = 5'd15, I_LUI = 5'd16, I_AUIPC = 5'd17, I_ERR = 5'd31;
  localparam bit M_ON = ENABLE_M != 0;
  typedef struct packed {
    logic [4:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     off;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
  } ent_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] op;
  logic       r_type, br, use_rs1, use_rs2, use_rd, acc, ret;
  ent_t       d, m, s;
  logic       m_v, s_v;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  always_comb begin
    op = I_ERR;
    case (opc)
      7'h33: op = (f3 == 3'd0 && f7 == 7'h00) ? I_ADD :
                  (f3 == 3'd0 && f7 == 7'h20) ? I_SUB :
                  (M_ON && f3 == 3'd0 && f7 == 7'h01) ? I_MUL :
                  (M_ON && f3 == 3'd1 && f7 == 7'h01) ? I_MULH :
                  (f3 == 3'd4 && f7 == 7'h00) ? I_XOR :
                  (f3 == 3'd6 && f7 == 7'h00) ? I_OR :
                  (f3 == 3'd7 && f7 == 7'h00) ? I_AND : I_ERR;
      7'h13: op = f3 == 3'd0 ? I_ADDI : I_ERR;
      7'h63: op = f3 == 3'd0 ? I_BEQ : f3 == 3'd1 ? I_BNE :
                  f3 == 3'd4 ? I_BLT : f3 == 3'd5 ? I_BGE : I_ERR;
      7'h03: op = f3 == 3'd2 ? I_LW : I_ERR;
      7'h23: op = f3 == 3'd2 ? I_SW : I_ERR;
      7'h6F: op = I_JAL;
      7'h37: op = I_LUI;
      7'h17: op = I_AUIPC;
      default: op = I_ERR;
    endcase
    if (instr == 32'd0) op = I_NULL;
  end
  assign r_type  = op inside {I_ADD, I_SUB, I_MUL, I_MULH, I_XOR, I_OR, I_AND};
  assign br      = op inside {I_BEQ, I_BNE, I_BLT, I_BGE};
  assign use_rs1 = r_type | br | op inside {I_ADDI, I_LW, I_SW};
  assign use_rs2 = r_type | br | op == I_SW;
  assign use_rd  = r_type | op inside {I_ADDI, I_LW, I_JAL, I_LUI, I_AUIPC};
  always_comb begin
    d.op  = op;
    d.rs1 = use_rs1 ? instr[19:15] : 5'd0;
    d.rs2 = use_rs2 ? instr[24:20] : 5'd0;
    d.rd  = use_rd ? instr[11:7] : 5'd0;
    d.off = br ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            op == I_JAL ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            op == I_LW ? {{20{instr[31]}}, instr[31:20]} :
            op == I_SW ? {{20{instr[31]}}, instr[31:25], instr[11:7]} : 32'd0;
    d.imm = op == I_ADDI ? {{20{instr[31]}}, instr[31:20]} :
            op inside {I_LUI, I_AUIPC} ? {instr[31:12], 12'd0} : 32'd0;
    d.pc  = pc_in;
  end
  assign in_ready = !s_v;
  assign acc      = in_valid & in_ready;
  assign ret      = m_v & out_ready;
  // S only fills while M is held, so S never holds data while M is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m           <= '0;
      s           <= '0;
      m_v         <= 1'b0;
      s_v         <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (acc && op == I_ERR && illegal_cnt != {CNT_W{1'b1}}) illegal_cnt <= illegal_cnt + 1'b1;
      if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (ret || !m_v) begin
        if (s_v) begin
          m   <= s;
          m_v <= 1'b1;
          s_v <= 1'b0;
        end else begin
          m_v <= acc;
          if (acc) m <= d;
        end
      end else if (acc) begin
        s   <= d;
        s_v <= 1'b1;
      end
    end
  end
  assign out_valid = m_v;
  assign op_type   = m.op;
  assign rs1       = m.rs1;
  assign rs2       = m.rs2;
  assign rd        = m.rd;
  assign offset    = m.off;
  assign immediate = m.imm;
  assign pc_out    = m.pc;
  assign illegal   = m.op == I_ERR;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, skid ordering, flush, saturation and async reset
module tb_decode_stage;
  localparam logic [4:0] I_NULL = 5'd0, I_MUL = 5'd3, I_ADDI = 5'd8, I_BEQ = 5'd9,
                         I_LW = 5'd13, I_SW = 5'd14, I_LUI = 5'd16, I_ERR = 5'd31;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] instr = 0, pc_in = 0;
  logic in_ready, out_valid, illegal;
  logic [4:0] op_type, rs1, rs2, rd;
  logic [31:0] offset, immediate, pc_out;
  logic [15:0] illegal_cnt;
  logic in_ready2, out_valid2, illegal2;
  logic [4:0] op_type2, rs12, rs22, rd2;
  logic [31:0] offset2, immediate2, pc_out2;
  logic [1:0] illegal_cnt2;
  int errors = 0, checks = 0;
  decode_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready), .op_type(op_type),
    .rs1(rs1), .rs2(rs2), .rd(rd), .offset(offset), .immediate(immediate), .illegal(illegal),
    .pc_out(pc_out), .illegal_cnt(illegal_cnt));
  decode_stage #(.ENABLE_M(0), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .instr(instr), .pc_in(pc_in), .out_valid(out_valid2),
    .out_ready(out_ready), .op_type(op_type2), .rs1(rs12), .rs2(rs22), .rd(rd2), .offset(offset2),
    .immediate(immediate2), .illegal(illegal2), .pc_out(pc_out2), .illegal_cnt(illegal_cnt2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    instr = i; pc_in = p; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  initial begin
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst op_type", op_type, I_NULL);
    check("rst cnt", illegal_cnt, 0);
    check("rst pc_out", pc_out, 0);
    @(negedge clk) rst_n = 1;
    drive(32'h00500093, 32'h100);
    check("addi valid", out_valid, 1);
    check("addi op", op_type, I_ADDI);
    check("addi rs1", rs1, 0);
    check("addi rd", rd, 1);
    check("addi imm", immediate, 5);
    check("addi pc", pc_out, 32'h100);
    check("addi illegal", illegal, 0);
    drive(32'hFE208EE3, 32'h104);
    check("beq op", op_type, I_BEQ);
    check("beq rs1", rs1, 1);
    check("beq rs2", rs2, 2);
    check("beq rd", rd, 0);
    check("beq off", offset, 32'hFFFFFFFC);
    drive(32'hFF812283, 32'h108);
    check("lw op", op_type, I_LW);
    check("lw rs1", rs1, 2);
    check("lw rd", rd, 5);
    check("lw rs2", rs2, 0);
    check("lw off", offset, 32'hFFFFFFF8);
    drive(32'hFE112E23, 32'h10C);
    check("sw op", op_type, I_SW);
    check("sw rs1", rs1, 2);
    check("sw rs2", rs2, 1);
    check("sw rd", rd, 0);
    check("sw off", offset, 32'hFFFFFFFC);
    drive(32'h123450B7, 32'h110);
    check("lui op", op_type, I_LUI);
    check("lui rd", rd, 1);
    check("lui imm", immediate, 32'h12345000);
    check("lui off", offset, 0);
    drive(32'h022081B3, 32'h114);
    check("mul op", op_type, I_MUL);
    check("mul rd", rd, 3);
    check("mul cnt", illegal_cnt, 0);
    check("nom op", op_type2, I_ERR);
    check("nom illegal", illegal2, 1);
    check("nom rd", rd2, 0);
    check("nom cnt", illegal_cnt2, 1);
    // skid fill and in-order drain
    @(negedge clk);
    out_ready = 0; instr = 32'h00500093; pc_in = 32'h200; in_valid = 1;
    @(negedge clk);
    check("A ready", in_ready, 1);
    check("A valid", out_valid, 1);
    instr = 32'h00A00113; pc_in = 32'h204;
    @(negedge clk);
    check("B stall ready", in_ready, 0);
    check("B head pc", pc_out, 32'h200);
    instr = 32'h00F00193; pc_in = 32'h208;
    @(negedge clk);
    check("C stall ready", in_ready, 0);
    check("A held pc", pc_out, 32'h200);
    check("A held rd", rd, 1);
    out_ready = 1;
    @(negedge clk);
    check("B out pc", pc_out, 32'h204);
    check("B out rd", rd, 2);
    check("B ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    check("C out pc", pc_out, 32'h208);
    check("C out imm", immediate, 15);
    @(negedge clk);
    check("drained", out_valid, 0);
    // flush with M and S full
    out_ready = 0; instr = 32'h00500093; pc_in = 32'h300; in_valid = 1;
    @(negedge clk);
    pc_in = 32'h304;
    @(negedge clk);
    check("full ready", in_ready, 0);
    flush = 1; instr = 32'hFFFFFFFF; pc_in = 32'h308;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("flush valid", out_valid, 0);
    check("flush ready", in_ready, 1);
    out_ready = 1;
    @(negedge clk);
    check("flush empty", out_valid, 0);
    // flush discards a same-cycle accept but still counts it
    out_ready = 0; instr = 32'h00500093; pc_in = 32'h400; in_valid = 1;
    @(negedge clk);
    flush = 1; instr = 32'hFFFFFFFF; pc_in = 32'h404;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("flush acc valid", out_valid, 0);
    check("flush acc ready", in_ready, 1);
    check("flush acc cnt", illegal_cnt, 1);
    check("flush acc cnt2", illegal_cnt2, 2);
    out_ready = 1;
    @(negedge clk);
    instr = 32'hFFFFFFFF; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      pc_in = 32'h500 + 32'(k * 4);
      @(negedge clk);
    end
    in_valid = 0;
    check("cnt16", illegal_cnt, 6);
    check("cnt sat", illegal_cnt2, 3);
    check("ill flag", illegal, 1);
    // async reset between edges
    out_ready = 0;
    drive(32'h00500093, 32'h600);
    check("pre rst valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("async valid", out_valid, 0);
    check("async cnt", illegal_cnt, 0);
    check("async cnt2", illegal_cnt2, 0);
    check("async ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
